pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Turns hazard and wait requests into per-stage stall and flush strobes.
- Sources of requests: EXE (taken jump, multi-cycle busy), ID (load-use) and MEM (bus access).
- Sequences the two-cycle jump redirect through the EXE/MEM-registered jump address, and bounds bus waits with a timeout.

Parameters:
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset (`RstEnable)
- jump_req_i  in  1  EXE resolved a taken jump/branch this cycle
- exe_busy_i  in  1  multi-cycle EXE unit (div) not done
- load_use_i  in  1  ID detected load-use hazard
- mem_req_i  in  1  MEM stage issuing bus access
- mem_ack_i  in  1  bus access completes this cycle
- pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o  out  1 each  hold stage register
- if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o  out  1 each  insert bubble (`FlushEnable)
- pc_sel_o  out  1  PC loads jump_addr_o from EXE/MEM instead of PC+4
- bus_err_o  out  1  one-cycle pulse on bus timeout
- state_o  out  2  current state (debug)

Behaviour:
- State register: RUN=0, MEM_WAIT=1, EXE_WAIT=2, JUMP=3. Updates on posedge clk_i.
- Strobe outputs are combinational from state and current inputs; they affect the same cycle's register edge.
- Reset (rst_i=1 at an edge): state->RUN, wait counter->0, bus_err_o->0. While rst_i=1, all stall/flush/pc_sel outputs are forced to 0. Reset mid-wait or mid-jump abandons the sequence with no further strobes.
- Priority within RUN: mem wait > exe busy > jump > load-use.
- RUN behaviour:
  - mem_req_i & !mem_ack_i: assert all four stalls and mem_wb_flush_o; next state MEM_WAIT; counter->1.
  - mem_req_i & mem_ack_i: zero-wait access; no strobes.
  - else exe_busy_i: assert pc/if_id/id_exe stalls and exe_mem_flush_o; next state EXE_WAIT.
  - else jump_req_i: assert if_id_flush_o and id_exe_flush_o; next state JUMP.
  - else load_use_i: assert pc_stall_o and if_id_stall_o plus id_exe_flush_o for that cycle only; state stays RUN.
- MEM_WAIT behaviour:
  - mem_ack_i=1: no strobes; next state RUN.
  - Else, if MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT: no stalls, mem_wb_flush_o=1, bus_err_o=1 next cycle; next state RUN.
  - Else: all four stalls and mem_wb_flush_o; counter+1.
  - jump_req_i, exe_busy_i and load_use_i are ignored; upstream holds them because its stage is stalled.
- EXE_WAIT behaviour:
  - exe_busy_i=1: same strobes as entry.
  - exe_busy_i=0: no strobes; next state RUN.
  - A mem_req_i & !mem_ack_i arriving here takes priority: MEM_WAIT strobes, next state MEM_WAIT.
- JUMP behaviour (one cycle after jump_req_i):
  - mem_req_i & !mem_ack_i: all four stalls, pc_sel_o=0; stay in JUMP; counter and timeout run as in MEM_WAIT.
  - Otherwise: pc_sel_o=1, if_id_flush_o=1, id_exe_flush_o=1; next state RUN.
  - jump_req_i and load_use_i are ignored in JUMP (wrong-path or bubble).
- A stage that is both stalled and flushed is never produced; the rules above avoid this combination.
- bus_err_o is registered, high for exactly one cycle.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds stall_cycles_o (out, 32) and flush_events_o (out, 32), both cleared by reset and wrapping at 2^32.
  - stall_cycles_o increments on every cycle with pc_stall_o=1.
  - flush_events_o increments once per jump (RUN->JUMP transition) and once per timeout.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with all inputs at 1 -> all strobes 0, state_o=0, bus_err_o=0.
- Mem wait: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack -> stalls and mem_wb_flush_o high for exactly 3 cycles, low on the ack cycle, then state_o=0.
- Jump: single jump_req_i pulse -> cycle t: if_id/id_exe flush=1, pc_sel_o=0; cycle t+1: pc_sel_o=1 and both flushes=1; cycle t+2: all strobes 0.
- Simultaneous: exe_busy_i=1 with jump_req_i=1 for 4 cycles, then exe_busy_i=0 -> EXE_WAIT for 4 cycles, then jump handled (t, t+1 pattern above).
- Timeout: MEM_TIMEOUT=4, mem_ack_i stuck 0 -> stall for 4 cycles, release on the timeout cycle, bus_err_o one-cycle pulse, state_o back to 0.
- Load-use: load_use_i=1 for 1 cycle in RUN -> pc/if_id stall and id_exe_flush_o for 1 cycle; with PIPE_CTRL_PERF_EN, stall_cycles_o increments by exactly 1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: converts EXE/ID/MEM hazard and wait requests into per-stage
// stall and flush strobes. Define PIPE_CTRL_PERF_EN to add stall/flush event counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       jump_req_i,
  input  logic       exe_busy_i,
  input  logic       load_use_i,
  input  logic       mem_req_i,
  input  logic       mem_ack_i,
  output logic       pc_stall_o,
  output logic       if_id_stall_o,
  output logic       id_exe_stall_o,
  output logic       exe_mem_stall_o,
  output logic       if_id_flush_o,
  output logic       id_exe_flush_o,
  output logic       exe_mem_flush_o,
  output logic       mem_wb_flush_o,
  output logic       pc_sel_o,
  output logic       bus_err_o,
  output logic [1:0] state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXE_WAIT = 2'd2,
    JUMP     = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TIMEOUT);
  localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
  logic if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
  logic pc_sel;
  logic mem_wait_req, tmo_hit;

  assign mem_wait_req = mem_req_i & ~mem_ack_i;
  assign tmo_hit      = TMO_EN && (cnt_q == TMO_VAL);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    bus_err_d     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_wait_req) begin
          {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall} = 4'b1111;
          mem_wb_flush = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          state_d      = MEM_WAIT;
        end else if (mem_req_i) begin
          // Zero-wait bus access masks every lower-priority request this cycle.
          state_d = RUN;
        end else if (exe_busy_i) begin
          {pc_stall, if_id_stall, id_exe_stall} = 3'b111;
          exe_mem_flush = 1'b1;
          state_d       = EXE_WAIT;
        end else if (jump_req_i) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          state_d      = JUMP;
        end else if (load_use_i) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_exe_flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = RUN;
        end else if (tmo_hit) begin
          mem_wb_flush = 1'b1;
          bus_err_d    = 1'b1;
          state_d      = RUN;
        end else begin
          {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall} = 4'b1111;
          mem_wb_flush = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end

      EXE_WAIT: begin
        if (mem_wait_req) begin
          {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall} = 4'b1111;
          mem_wb_flush = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          state_d      = MEM_WAIT;
        end else if (exe_busy_i) begin
          {pc_stall, if_id_stall, id_exe_stall} = 3'b111;
          exe_mem_flush = 1'b1;
        end else begin
          state_d = RUN;
        end
      end

      JUMP: begin
        // The redirect waits for MEM to finish so the jump address stays in EXE/MEM.
        if (mem_wait_req) begin
          if (tmo_hit) begin
            mem_wb_flush = 1'b1;
            bus_err_d    = 1'b1;
            state_d      = RUN;
          end else begin
            {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall} = 4'b1111;
            mem_wb_flush = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
          end
        end else begin
          pc_sel       = 1'b1;
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          state_d      = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign pc_stall_o      = pc_stall      & ~rst_i;
  assign if_id_stall_o   = if_id_stall   & ~rst_i;
  assign id_exe_stall_o  = id_exe_stall  & ~rst_i;
  assign exe_mem_stall_o = exe_mem_stall & ~rst_i;
  assign if_id_flush_o   = if_id_flush   & ~rst_i;
  assign id_exe_flush_o  = id_exe_flush  & ~rst_i;
  assign exe_mem_flush_o = exe_mem_flush & ~rst_i;
  assign mem_wb_flush_o  = mem_wb_flush  & ~rst_i;
  assign pc_sel_o        = pc_sel        & ~rst_i;
  assign bus_err_o       = bus_err_q;
  assign state_o         = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;
  logic        flush_evt;

  assign flush_evt = ((state_q == RUN) && (state_d == JUMP)) || bus_err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (pc_stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_evt)  flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic, checked
// against a flag-based behavioural model of the sequencing rules.
module tb_pipe_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i = 1'b1, jump_req_i = 1'b1, exe_busy_i = 1'b1, load_use_i = 1'b1;
  logic mem_req_i = 1'b1, mem_ack_i = 1'b1;
  logic pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o;
  logic if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o;
  logic pc_sel_o, bus_err_o;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o, flush_events_o;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .jump_req_i(jump_req_i), .exe_busy_i(exe_busy_i),
    .load_use_i(load_use_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .id_exe_stall_o(id_exe_stall_o), .exe_mem_stall_o(exe_mem_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_exe_flush_o(id_exe_flush_o),
    .exe_mem_flush_o(exe_mem_flush_o), .mem_wb_flush_o(mem_wb_flush_o),
    .pc_sel_o(pc_sel_o), .bus_err_o(bus_err_o), .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
`endif
  );

  // stall = {pc, if_id, id_exe, exe_mem}; flush = {if_id, id_exe, exe_mem, mem_wb}
  typedef struct packed {
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        pc_sel;
    logic        bus_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  // Model: which wait the pipeline is in, how long the bus has been stuck,
  // pending bus error and the event tallies.
  bit          in_mem_wait = 0, in_exe_wait = 0, jump_pending = 0, err_pending = 0;
  int          waited = 0;
  int unsigned stalls_seen = 0, flushes_seen = 0;

  task automatic cycle(input bit r, input bit jr, input bit eb, input bit lu,
                       input bit mr, input bit ma);
    exp_t e;
    bit   stuck, timed_out;
    bit   nxt_mem, nxt_exe, nxt_jump, nxt_err;
    int   nxt_wait;
    @(posedge clk);
    #1;
    rst_i = r; jump_req_i = jr; exe_busy_i = eb; load_use_i = lu;
    mem_req_i = mr; mem_ack_i = ma;

    e = '0;
    e.state     = in_mem_wait ? 2'd1 : in_exe_wait ? 2'd2 : jump_pending ? 2'd3 : 2'd0;
    e.bus_err   = err_pending;
    e.stall_cnt = stalls_seen;
    e.flush_cnt = flushes_seen;
    nxt_mem = 0; nxt_exe = 0; nxt_jump = 0; nxt_err = 0; nxt_wait = 0;

    if (r) begin
      sb_q.push_back(e);
      in_mem_wait = 0; in_exe_wait = 0; jump_pending = 0; err_pending = 0;
      waited = 0; stalls_seen = 0; flushes_seen = 0;
      return;
    end

    stuck     = in_mem_wait ? !ma : (mr && !ma);
    timed_out = stuck && (in_mem_wait || jump_pending) && (waited == TMO);

    if (timed_out) begin
      e.flush = 4'b0001;
      nxt_err = 1;
      flushes_seen++;
    end else if (stuck) begin
      e.stall  = 4'b1111;
      e.flush  = 4'b0001;
      nxt_wait = waited + 1;
      if (jump_pending) nxt_jump = 1;
      else nxt_mem = 1;
    end else if (in_mem_wait) begin
      // bus acknowledged: back to normal flow with no strobes
    end else if (jump_pending) begin
      e.pc_sel = 1;
      e.flush  = 4'b1100;
    end else if (in_exe_wait) begin
      if (eb) begin
        e.stall = 4'b1110;
        e.flush = 4'b0010;
        nxt_exe = 1;
      end
    end else if (mr) begin
      // zero-wait access hides everything else
    end else if (eb) begin
      e.stall = 4'b1110;
      e.flush = 4'b0010;
      nxt_exe = 1;
    end else if (jr) begin
      e.flush  = 4'b1100;
      nxt_jump = 1;
      flushes_seen++;
    end else if (lu) begin
      e.stall = 4'b1100;
      e.flush = 4'b0100;
    end

    if (e.stall[3]) stalls_seen++;
    sb_q.push_back(e);
    in_mem_wait = nxt_mem; in_exe_wait = nxt_exe; jump_pending = nxt_jump;
    err_pending = nxt_err; waited = nxt_wait;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stalls", 32'({pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o}),
            32'(e.stall));
        chk("flushes", 32'({if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o}),
            32'(e.flush));
        chk("pc_sel", 32'(pc_sel_o), 32'(e.pc_sel));
        chk("bus_err", 32'(bus_err_o), 32'(e.bus_err));
        chk("state", 32'(state_o), 32'(e.state));
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles_o, e.stall_cnt);
        chk("flush_events", flush_events_o, e.flush_cnt);
`endif
      end
    end
  end

  initial begin : stimulus
    bit jr, eb, lu, mr, ma, r;
    // reset with every request asserted
    cycle(1, 1, 1, 1, 1, 1);
    cycle(1, 1, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // mem wait of three cycles then ack
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // single jump pulse
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // exe busy together with a held jump
    repeat (4) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // bus stuck until timeout
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // load-use bubble
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // jump whose redirect is held by a stuck bus, then a timeout in JUMP
    cycle(0, 1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    // reset in the middle of a wait
    repeat (2) cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      mr = in_mem_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
      ma = ($urandom_range(0, 3) == 0);
      jr = ($urandom_range(0, 4) == 0);
      eb = ($urandom_range(0, 5) == 0);
      lu = ($urandom_range(0, 4) == 0);
      cycle(r, jr, eb, lu, mr, ma);
    end
    cycle(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
